// File: rtl/led_dimmer_multi.sv
`default_nettype none
// ============================================================================
// Module   : led_dimmer_multi
// Purpose  : Multi-channel PWM LED dimmer. A shared prescaled PWM timebase
//            drives CHANNELS LED outputs, each with a double-buffered duty
//            register. Two debounced buttons provide control:
//              buton1 short press -> select next channel
//              buton1 long press  -> toggle master enable
//              buton2 press       -> step duty of selected channel
// Ports    : clock        - system clock, rising edge
//            reset        - synchronous, active-high
//            buton1       - raw async button (select / enable)
//            buton2       - raw async button (duty step)
//            led          - registered PWM outputs, one per channel
//            sel          - currently selected channel index
//            enabled      - master enable (0 forces all led low)
//            period_start - one-cycle pulse on first cycle of each PWM period
// Revision : 1.0 - initial release
// ============================================================================
module led_dimmer_multi #(
    parameter int CHANNELS          = 3,
    parameter int PWM_BITS          = 4,
    parameter int PRESCALE          = 100,
    parameter int DEBOUNCE_CYCLES   = 500_000,
    parameter int LONG_PRESS_CYCLES = 240_000_000,
    parameter int SEL_W             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                buton1,
    input  logic                buton2,
    output logic [CHANNELS-1:0] led,
    output logic [SEL_W-1:0]    sel,
    output logic                enabled,
    output logic                period_start
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);

    localparam logic [PWM_BITS-1:0] c_PWM_MAX   = '1;
    localparam logic [DB_W-1:0]     c_DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRE_W-1:0]    c_PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [HOLD_W-1:0]   c_HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [SEL_W-1:0]    c_SEL_LAST  = SEL_W'(CHANNELS - 1);

    // ------------------------------------------------------------------
    // Button input path: 2-flop synchroniser followed by a debouncer.
    // Bit 0 = buton1, bit 1 = buton2.
    // ------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_db;
    logic [1:0] w_accept;

    assign w_raw = {buton2, buton1};

    generate
        for (genvar b = 0; b < 2; b++) begin : g_btn
            logic [1:0]      r_sync;
            logic            r_db;
            logic [DB_W-1:0] r_cnt;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_sync <= '0;
                    r_db   <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_sync <= {r_sync[0], w_raw[b]};
                    if (r_sync[1] != r_db) begin
                        if (r_cnt == c_DB_LAST) begin
                            r_db  <= r_sync[1];
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + DB_W'(1);
                        end
                    end else begin
                        // Bounce back to the accepted level restarts the count
                        r_cnt <= '0;
                    end
                end
            end

            assign w_db[b]     = r_db;
            // High in the cycle whose edge flips the debounced level
            assign w_accept[b] = (r_sync[1] != r_db) && (r_cnt == c_DB_LAST);
        end
    endgenerate

    // Accepted change goes to the opposite of the current debounced level
    logic w_b1_release;
    logic w_b2_press;

    assign w_b1_release = w_accept[0] &  w_db[0];
    assign w_b2_press   = w_accept[1] & ~w_db[1];

    // ------------------------------------------------------------------
    // Shared PWM timebase
    // ------------------------------------------------------------------
    logic [PRE_W-1:0]    r_pre;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_period_start;
    logic                w_tick;
    logic                w_wrap;

    assign w_tick = (r_pre == c_PRE_LAST);
    assign w_wrap = w_tick && (r_pwm_cnt == c_PWM_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pre          <= '0;
            r_pwm_cnt      <= '0;
            r_period_start <= 1'b0;
        end else begin
            if (w_tick) begin
                r_pre     <= '0;
                r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
            // Registered so it is high exactly while pwm_cnt=0 and prescaler=0
            r_period_start <= w_wrap;
        end
    end

    // ------------------------------------------------------------------
    // buton1: short press selects next channel, long press toggles enable
    // ------------------------------------------------------------------
    logic [HOLD_W-1:0] r_hold;
    logic              r_long;
    logic [SEL_W-1:0]  r_sel;
    logic              r_enabled;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold    <= '0;
            r_long    <= 1'b0;
            r_sel     <= '0;
            r_enabled <= 1'b1;
        end else if (w_b1_release) begin
            if (!r_long) begin
                r_sel <= (r_sel == c_SEL_LAST) ? '0 : r_sel + SEL_W'(1);
            end
            r_long <= 1'b0;
            r_hold <= '0;
        end else if (w_db[0] && !r_long) begin
            // Fires on the LONG_PRESS_CYCLES-th held cycle; the long flag
            // then freezes the counter so the toggle happens only once.
            if (r_hold == c_HOLD_LAST) begin
                r_enabled <= ~r_enabled;
                r_long    <= 1'b1;
            end else begin
                r_hold <= r_hold + HOLD_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel double-buffered duty and PWM compare
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] w_led_next;
    logic [CHANNELS-1:0] r_led;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            localparam logic [SEL_W-1:0] c_IDX = SEL_W'(i);

            logic [PWM_BITS-1:0] r_duty_pend;
            logic [PWM_BITS-1:0] r_duty_act;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_duty_pend <= '0;
                    r_duty_act  <= '0;
                end else begin
                    // Uses the pre-update sel if a select happens on the same edge
                    if (w_b2_press && (r_sel == c_IDX)) begin
                        r_duty_pend <= r_duty_pend + PWM_BITS'(1);
                    end
                    // Reload only at period boundary to avoid mid-period glitches
                    if (w_wrap) begin
                        r_duty_act <= r_duty_pend;
                    end
                end
            end

            assign w_led_next[i] = r_enabled &&
                                   ((r_duty_act == c_PWM_MAX) || (r_pwm_cnt < r_duty_act));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_next;
        end
    end

    assign led          = r_led;
    assign sel          = r_sel;
    assign enabled      = r_enabled;
    assign period_start = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_led_dimmer_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_dimmer_multi
// Purpose  : Directed self-checking bench for led_dimmer_multi with small
//            timing parameters (period = 4 * 16 = 64 cycles, debounce 8,
//            long press 64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_dimmer_multi;

    localparam int CH     = 3;
    localparam int SW     = 2;
    localparam int PERIOD = 64;

    logic          clock  = 1'b0;
    logic          reset  = 1'b1;
    logic          buton1 = 1'b0;
    logic          buton2 = 1'b0;
    logic [CH-1:0] led;
    logic [SW-1:0] sel;
    logic          enabled;
    logic          period_start;

    int checks = 0;
    int errors = 0;
    int cnt [CH];

    led_dimmer_multi #(
        .CHANNELS          (CH),
        .PWM_BITS          (4),
        .PRESCALE          (4),
        .DEBOUNCE_CYCLES   (8),
        .LONG_PRESS_CYCLES (64)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .buton1       (buton1),
        .buton2       (buton2),
        .led          (led),
        .sel          (sel),
        .enabled      (enabled),
        .period_start (period_start)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit before sampling
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Step until period_start is seen (bounded), return cycles taken
    task automatic wait_ps(input string tag, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!period_start && n < 200);
        check(tag, period_start, 1);
    endtask

    // Count high cycles per channel over one full PWM period
    task automatic measure();
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        for (int k = 0; k < PERIOD; k++) begin
            step(1);
            for (int c = 0; c < CH; c++) cnt[c] += int'(led[c]);
        end
    endtask

    task automatic press(input int which, input int hold);
        if (which == 1) buton1 = 1'b1;
        else            buton2 = 1'b1;
        step(hold);
        buton1 = 1'b0;
        buton2 = 1'b0;
        step(20);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // ---------------- reset state and timebase ----------------
        step(3);
        check("rst_led", led, 0);
        check("rst_sel", sel, 0);
        check("rst_enabled", enabled, 1);
        check("rst_period_start", period_start, 0);
        reset = 1'b0;
        wait_ps("ps_first_seen", n);
        check("ps_first_gap", n, 64);
        wait_ps("ps_second_seen", n);
        check("ps_second_gap", n, 64);
        step(1);
        check("ps_one_cycle", period_start, 0);
        check("idle_led", led, 0);

        // ---------------- 5 steps on channel 0 ----------------
        repeat (5) press(2, 20);
        wait_ps("ps_b", n);
        measure();
        check("duty5_ch0", cnt[0], 20);
        check("duty5_ch1", cnt[1], 0);
        check("duty5_ch2", cnt[2], 0);
        check("ps_align_b", period_start, 1);

        // ---------------- select ch1, change on release ----------------
        buton1 = 1'b1;
        step(20);
        check("sel_during_hold", sel, 0);
        buton1 = 1'b0;
        step(20);
        check("sel_after_release1", sel, 1);

        repeat (15) press(2, 20);
        wait_ps("ps_c15", n);
        measure();
        check("duty15_ch1_full", cnt[1], 64);
        check("duty15_ch0_kept", cnt[0], 20);
        press(2, 20);
        wait_ps("ps_c16", n);
        measure();
        check("duty_wrap_ch1", cnt[1], 0);

        press(1, 20);
        check("sel_after_release2", sel, 2);
        press(1, 20);
        check("sel_wrap_to_0", sel, 0);

        // ---------------- long press disables ----------------
        buton1 = 1'b1;
        step(73);
        check("long_before_64", enabled, 1);
        step(1);
        check("long_at_64", enabled, 0);
        step(1);
        check("led_forced_off", led, 0);
        step(25);
        check("long_no_repeat", enabled, 0);
        buton1 = 1'b0;
        step(20);
        check("long_sel_kept", sel, 0);
        check("long_stays_off", enabled, 0);

        // Step while disabled: stored, not shown
        press(2, 20);
        wait_ps("ps_dis", n);
        measure();
        check("disabled_ch0_dark", cnt[0], 0);

        // Second long press restores output with stored duties
        press(1, 100);
        check("long_reenable", enabled, 1);
        check("long2_sel_kept", sel, 0);
        wait_ps("ps_en", n);
        measure();
        check("reenabled_ch0", cnt[0], 24);
        check("reenabled_ch1", cnt[1], 0);

        // ---------------- bouncy buton2 -> single step ----------------
        for (int k = 0; k < 4; k++) begin
            buton2 = 1'b1;
            step(5);
            buton2 = 1'b0;
            step(5);
        end
        press(2, 20);
        wait_ps("ps_bounce", n);
        measure();
        check("bounce_one_step", cnt[0], 28);

        // ---------------- mid-period step 3 -> 4 on ch2 ----------------
        press(1, 20);
        press(1, 20);
        check("sel_ch2", sel, 2);
        repeat (3) press(2, 20);
        wait_ps("ps_g", n);
        measure();
        check("duty3_ch2", cnt[2], 12);
        check("ps_align_g", period_start, 1);
        cnt[2] = 0;
        for (int k = 0; k < PERIOD; k++) begin
            if (k == 2)  buton2 = 1'b1;
            if (k == 22) buton2 = 1'b0;
            step(1);
            cnt[2] += int'(led[2]);
        end
        check("midperiod_old_duty", cnt[2], 12);
        check("ps_align_mid", period_start, 1);
        measure();
        check("next_period_new_duty", cnt[2], 16);

        // ---------------- reset during buton1 hold ----------------
        buton1 = 1'b1;
        step(40);
        check("pre_reset_enabled", enabled, 1);
        reset  = 1'b1;
        buton1 = 1'b0;
        step(1);
        check("midrst_led", led, 0);
        check("midrst_sel", sel, 0);
        check("midrst_enabled", enabled, 1);
        check("midrst_period_start", period_start, 0);
        reset = 1'b0;
        step(100);
        check("postrst_no_toggle", enabled, 1);
        check("postrst_sel", sel, 0);
        wait_ps("ps_h", n);
        measure();
        check("postrst_duties_cleared", cnt[0] + cnt[1] + cnt[2], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
